// File: rtl/keypad_emulator.sv
// keypad_emulator: scripted 4x4 keypad that answers column scans with row sense
// clk, rst            : clock, synchronous active-high reset
// ev_valid/ev_ready   : push handshake for a key event {ev_row, ev_col, ev_hold, ev_gap}
// flush               : drop queued events and release the key
// col_scan / row_out  : scanner column drive in, row sense out (line n on bit 3-n)
// busy, ev_done, fill : activity flag, end-of-event pulse, FIFO occupancy
module keypad_emulator #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic [1:0]               ev_row,
  input  logic [1:0]               ev_col,
  input  logic [CNT_W-1:0]         ev_hold,
  input  logic [CNT_W-1:0]         ev_gap,
  input  logic                     flush,
  input  logic [3:0]               col_scan,
  output logic [3:0]               row_out,
  output logic                     busy,
  output logic                     ev_done,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4 + 2 * CNT_W;
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
  state_t r_state, w_next;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_fill;
  logic [1:0] r_row, r_col, w_hrow, w_hcol;
  logic [CNT_W-1:0] r_cnt, r_gap, w_cnt, w_hhold, w_hgap;
  logic [3:0] r_rout;
  logic r_done, w_done, w_pop, w_push;
  assign {w_hrow, w_hcol, w_hhold, w_hgap} = r_mem[r_rp];
  assign ev_ready = (r_fill < (AW+1)'(DEPTH)) && !flush;
  assign w_push = ev_valid && ev_ready;
  assign busy = (r_state != IDLE) || (r_fill != '0);
  assign fill = r_fill;
  assign row_out = r_rout;
  assign ev_done = r_done;
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt - CNT_W'(1);
    w_done = 1'b0;
    w_pop = 1'b0;
    if (r_state == IDLE) begin
      w_cnt = r_cnt;
      if (r_fill != '0) begin
        w_pop = 1'b1;
        w_next = PRESS;
        w_cnt = (w_hhold == '0) ? CNT_W'(1) : w_hhold;
      end
    end else if (r_state == PRESS && r_cnt == CNT_W'(1)) begin
      w_next = (r_gap != '0) ? GAP : IDLE;
      w_cnt = r_gap;
      w_done = (r_gap == '0);
    end else if (r_state == GAP && r_cnt == CNT_W'(1)) begin
      w_next = IDLE;
      w_done = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= IDLE;
      r_fill <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_row <= '0;
      r_col <= '0;
      r_gap <= '0;
      r_rout <= 4'b0000;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_done <= w_done;
      r_rout <= (r_state == PRESS && col_scan[~r_col]) ? (4'b1000 >> r_row) : 4'b0000;
      r_fill <= r_fill + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
        r_row <= w_hrow;
        r_col <= w_hcol;
        r_gap <= w_hgap;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {ev_row, ev_col, ev_hold, ev_gap};
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed key scripts checked against a timeline model of the keypad
module tb_keypad_emulator;
  typedef struct packed {logic [1:0] r; logic [1:0] c; logic [19:0] h; logic [19:0] g;} ev_t;
  logic clk = 0, rst = 1, ev_valid = 0, flush = 0;
  logic [1:0] ev_row = 0, ev_col = 0;
  logic [19:0] ev_hold = 0, ev_gap = 0;
  logic [3:0] col_scan = 0;
  logic ev_ready, busy, ev_done;
  logic [3:0] row_out, fill;
  int n_cmp = 0, n_err = 0;
  keypad_emulator #(.DEPTH(8), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_row(ev_row), .ev_col(ev_col), .ev_hold(ev_hold), .ev_gap(ev_gap),
    .flush(flush), .col_scan(col_scan), .row_out(row_out), .busy(busy),
    .ev_done(ev_done), .fill(fill)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  ev_t q[$];
  ev_t cur;
  logic m_act = 0, m_on = 0, m_done = 0, rdy;
  logic [3:0] m_row = 0;
  longint k = 0, ts = 0, hh = 0;
  initial forever begin
    @(posedge clk);
    k++;
    if (rst || flush) begin
      q.delete();
      m_act = 0;
      m_row = 0;
      m_done = 0;
      m_on = 1;
    end else begin
      rdy = q.size() < 8;
      m_row = (m_act && k - 1 >= ts && k - 1 < ts + hh && (col_scan & (4'b1000 >> cur.c)) != 0)
              ? (4'b1000 >> cur.r) : 4'b0000;
      m_done = m_act && (k == ts + hh + longint'(cur.g));
      if (m_done) m_act = 0;
      else if (!m_act && q.size() > 0) begin
        cur = q.pop_front();
        hh = (cur.h == 0) ? 1 : longint'(cur.h);
        ts = k;
        m_act = 1;
      end
      if (ev_valid && rdy) q.push_back({ev_row, ev_col, ev_hold, ev_gap});
    end
  end
  initial forever begin
    @(negedge clk);
    if (m_on) begin
      chk("row_out", row_out, m_row);
      chk("ev_done", ev_done, m_done);
      chk("busy", busy, m_act || q.size() > 0);
      chk("fill", fill, q.size());
      chk("ev_ready", ev_ready, q.size() < 8 && !flush);
    end
  end
  logic rot = 0;
  logic [3:0] last_row = 0;
  int n_hi = 0, n_done = 0;
  longint done_k = 0, acc_k = 0, a0 = 0;
  task automatic tick();
    @(posedge clk);
    #1;
    if (rot) col_scan = {col_scan[0], col_scan[3:1]};
    if (row_out != 0) begin
      n_hi++;
      last_row = row_out;
    end
    if (ev_done) begin
      n_done++;
      done_k = k;
    end
  endtask
  task automatic clr();
    n_hi = 0;
    n_done = 0;
    last_row = 0;
  endtask
  task automatic push(input logic [1:0] r, input logic [1:0] c, input logic [19:0] h, input logic [19:0] g);
    logic w;
    int n = 0;
    ev_valid = 1;
    {ev_row, ev_col, ev_hold, ev_gap} = {r, c, h, g};
    do begin
      w = ev_ready;
      tick();
      n++;
    end while (!w && n < 1000);
    chk("push_accepted", w, 1);
    acc_k = k;
    ev_valid = 0;
  endtask
  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    ev_valid = 1;
    {ev_row, ev_col, ev_hold, ev_gap} = {2'd1, 2'd2, 20'd3, 20'd1};
    col_scan = 4'b1111;
    tick();
    tick();
    rst = 0;
    ev_valid = 0;
    col_scan = 0;
    chk("rst_row", row_out, 0);
    chk("rst_fill", fill, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ev_ready, 1);
    tick();
    chk("rst_not_taken", fill, 0);
    clr();
    rot = 1;
    col_scan = 4'b1000;
    push(2'd0, 2'd1, 20'd5, 20'd3);
    wait_idle(50);
    tick();
    chk("A_done_lat", 32'(done_k - acc_k), 9);
    chk("A_done_cnt", n_done, 1);
    chk("A_row", last_row, 4'b1000);
    clr();
    rot = 0;
    col_scan = 4'b0100;
    for (int i = 0; i < 3; i++) push(2'd1, 2'd1, 20'd4, 20'd2);
    wait_idle(100);
    tick();
    chk("L_row_cycles", n_hi, 12);
    chk("L_done_cnt", n_done, 3);
    chk("L_row", last_row, 4'b0100);
    rot = 1;
    col_scan = 4'b1000;
    push(2'd0, 2'd0, 20'd60, 20'd0);
    for (int i = 1; i <= 8; i++) push(2'(i % 4), 2'((i / 4) % 4), 20'(4 + i % 2), 20'(i % 3));
    chk("full_fill", fill, 8);
    chk("full_ready", ev_ready, 0);
    a0 = k;
    push(2'd1, 2'd2, 20'd5, 20'd0);
    chk("ninth_waited", 32'(acc_k - a0 > 40), 1);
    chk("ninth_fill", fill, 8);
    for (int i = 10; i < 20; i++) push(2'(i % 4), 2'((i / 4) % 4), 20'(4 + i % 2), 20'(i % 3));
    wait_idle(1000);
    tick();
    clr();
    rot = 0;
    col_scan = 4'b1000;
    push(2'd3, 2'd0, 20'd0, 20'd0);
    wait_idle(20);
    tick();
    chk("submit_hi", n_hi, 1);
    chk("submit_row", last_row, 4'b0001);
    chk("submit_done", n_done, 1);
    chk("submit_lat", 32'(done_k - acc_k), 2);
    push(2'd2, 2'd0, 20'd100, 20'd0);
    a0 = acc_k;
    for (int i = 0; i < 3; i++) push(2'd1, 2'd1, 20'd5, 20'd1);
    chk("pre_flush_fill", fill, 3);
    while (k < a0 + 11) tick();
    chk("pre_flush_row", row_out, 4'b0010);
    clr();
    flush = 1;
    ev_valid = 1;
    {ev_row, ev_col, ev_hold, ev_gap} = {2'd0, 2'd0, 20'd2, 20'd0};
    tick();
    flush = 0;
    ev_valid = 0;
    chk("flush_row", row_out, 0);
    chk("flush_fill", fill, 0);
    chk("flush_busy", busy, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("flush_no_done", n_done, 0);
    chk("flush_no_row", n_hi, 0);
    chk("flush_still_idle", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable 4x4 keypad model that sits on the scanner side of the keypad interface and answers column scans the way a physical keypad does. It takes a queued script of key events (row, column, hold time, release gap). While a key is held, it asserts the matching row line whenever the scanner drives that key's column. Its uses are on-chip self-test of the host/player letter-entry path, including multi-tap letters and submit keys, and bench-free stimulus for the wireless hangman top level.

## Interface
- DEPTH, 8: event FIFO entries (power of two, >=2)
- CNT_W, 20: width of hold/gap counters (cycles)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ev_valid  in  1  event offered
- ev_ready  out  1  FIFO can accept; event is taken on a cycle where ev_valid && ev_ready
- ev_row  in  2  key row 0..3
- ev_col  in  2  key column 0..3
- ev_hold  in  CNT_W  cycles the key stays pressed (0 treated as 1)
- ev_gap  in  CNT_W  released cycles after the press before the next event (0 allowed)
- flush  in  1  drop all queued events and release the key
- col_scan  in  4  scanner column drive, active-high; column c = bit 3-c
- row_out  out  4  row sense to scanner, active-high; row r = bit 3-r (R0 = 4'b1000, R3 = 4'b0001)
- busy  out  1  state != IDLE or FIFO non-empty
- ev_done  out  1  one-cycle pulse when an event's gap completes
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO: DEPTH entries of {row, col, hold, gap}. Registered read/write pointers with wrap. ev_ready = (fill < DEPTH) && !flush. Push when full is impossible. A push and a pop in the same cycle leave fill unchanged.
- FSM states:
  - IDLE: if fill > 0, pop the head into the current-key registers, load cnt = max(hold,1), go to PRESS.
  - PRESS: the key is down. cnt decrements each cycle. When cnt == 1:
    - if gap > 0: load cnt = gap, go to GAP;
    - else: pulse ev_done, go to IDLE.
  - GAP: the key is up. cnt decrements. When cnt == 1, pulse ev_done and go to IDLE.
- Row drive is registered: row_out <= (state == PRESS && col_scan[3-cur_col]) ? (4'b1000 >> cur_row) : 4'b0000.
  - If col_scan has several bits set, the row asserts if any of them matches the current column.
  - A scan of any other column gives row_out = 0.
- Only one key is ever down. Chords are not modelled.
- flush: on the edge where flush = 1:
  - FIFO emptied (fill = 0);
  - state -> IDLE;
  - row_out -> 0;
  - no ev_done pulse;
  - any ev_valid in that cycle is dropped.
- rst has priority over flush. Reset values:
  - row_out = 0, ev_done = 0, busy = 0, fill = 0;
  - state = IDLE, pointers = 0, cnt = 0;
  - ev_ready = 1 in the first cycle after reset.
- Reset mid-press releases the key on the reset edge. The queued script is lost.

## Timing
- Event accepted at edge E0 with the FIFO empty and state IDLE:
  - E1: state -> PRESS;
  - first edge where row_out can go high is E2, using col_scan sampled before E2.
- PRESS lasts exactly max(hold,1) cycles. GAP lasts exactly gap cycles.
- row_out lags the PRESS/GAP boundary by one cycle, because it is registered.
- ev_done is high for the one cycle following the final GAP cycle (or the final PRESS cycle if gap = 0).
- Back-to-back events: event N+1 enters PRESS one cycle after event N's ev_done edge (the IDLE cycle). Minimum period per event = hold + gap + 1 cycles.
- An event pushed while an earlier event is in progress does not affect the in-flight key.
- busy falls on the same edge the FSM returns to IDLE with fill = 0.

## Test plan
- Reset: hold rst for 2 cycles with ev_valid = 1 and col_scan = 4'b1111 -> row_out = 0, fill = 0, busy = 0, ev_ready = 1. The event offered during reset is not accepted.
- Single 'A' key: event row0/col1 with hold = 5, gap = 3; col_scan one-hot rotating each cycle (1000, 0100, 0010, 0001).
  - row_out = 4'b1000 exactly on cycles after col_scan = 4'b0100 while in PRESS, else 0;
  - ev_done once, 9 cycles after acceptance.
- Multi-tap 'L': three events row1/col1, hold = 4, gap = 2; col_scan held at 4'b0100 -> row_out = 4'b0100 for three 4-cycle pulses separated by 3 low cycles (2 gap + 1 IDLE); three ev_done pulses.
- FIFO full: push 8 events with the FSM busy -> ev_ready low at fill = 8. A 9th offer is not accepted until a pop. Pointer wrap is verified over 20 total events, replayed in order.
- hold = 0, gap = 0: submit key row3/col0 with col_scan = 4'b1000 -> a single 1-cycle row_out = 4'b0001 pulse; ev_done the cycle after PRESS.
- flush mid-press (event row2/col0, hold = 100, cycle 10) with 3 events queued -> row_out = 0 next cycle, fill = 0, busy = 0, no ev_done. A simultaneous ev_valid is dropped.
